// File: rtl/comm_pkg.sv
// Shared types and constants for the UART command master.
package comm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_RESP
  } cm_state_t;

  localparam int unsigned UART_FRAME_BITS  = 10;
  localparam int unsigned DEFAULT_BAUD_DIV = 2604;

endpackage

// File: rtl/uart_xcvr.sv
// 8N1 UART transceiver: independent transmit and receive halves sharing a baud divisor.
import comm_pkg::*;

module uart_xcvr #(
  parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       TX,
  input  logic       RX,
  output logic       rx_rdy,
  output logic [7:0] rx_data
);

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam int unsigned BW = $clog2(UART_FRAME_BITS);
  localparam logic [CW-1:0] BIT_LAST   = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_M1    = CW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] FRAME_LAST = BW'(UART_FRAME_BITS - 1);

  logic          tx_q, tx_d;
  logic          tx_act_q, tx_act_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [BW-1:0] tx_bit_q, tx_bit_d;
  logic [8:0]    tx_sh_q, tx_sh_d;

  logic          rx_s1_q, rx_s2_q;
  logic          rx_act_q, rx_act_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [BW-1:0] rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_rdy_q, rx_rdy_d;

  // Transmit: start bit on accept, then shift data LSB-first followed by the stop bit.
  // tx_done flags the last cycle of the stop bit so the next byte follows after one idle cycle.
  always_comb begin
    tx_d     = tx_q;
    tx_act_d = tx_act_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_done  = 1'b0;
    if (tx_act_q) begin
      if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (tx_bit_q == FRAME_LAST) begin
          tx_act_d = 1'b0;
          tx_done  = 1'b1;
          tx_d     = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
          tx_d     = tx_sh_q[0];
          tx_sh_d  = {1'b1, tx_sh_q[8:1]};
        end
      end else begin
        tx_cnt_d = tx_cnt_q + 1'b1;
      end
    end else if (tx_start) begin
      tx_act_d = 1'b1;
      tx_cnt_d = '0;
      tx_bit_d = '0;
      tx_d     = 1'b0;
      tx_sh_d  = {1'b1, tx_data};
    end
  end

  // Receive: after a start edge wait half a bit, then sample each bit at its centre.
  // A high start sample is a glitch; a low stop sample drops the byte.
  always_comb begin
    rx_act_d  = rx_act_q;
    rx_cnt_d  = rx_cnt_q;
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    rx_rdy_d  = 1'b0;
    if (!rx_act_q) begin
      if (!rx_s2_q) begin
        rx_act_d = 1'b1;
        rx_cnt_d = HALF_M1;
        rx_bit_d = '0;
      end
    end else if (rx_cnt_q != '0) begin
      rx_cnt_d = rx_cnt_q - 1'b1;
    end else begin
      rx_cnt_d = BIT_LAST;
      if (rx_bit_q == '0) begin
        if (rx_s2_q) rx_act_d = 1'b0;
        else         rx_bit_d = rx_bit_q + 1'b1;
      end else if (rx_bit_q == FRAME_LAST) begin
        rx_act_d = 1'b0;
        if (rx_s2_q) begin
          rx_data_d = rx_sh_q;
          rx_rdy_d  = 1'b1;
        end
      end else begin
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 1'b1;
      end
    end
  end

  // State registers for both halves plus the RX double-flop synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q      <= 1'b1;
      tx_act_q  <= 1'b0;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '1;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_act_q  <= 1'b0;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      rx_rdy_q  <= 1'b0;
    end else begin
      tx_q      <= tx_d;
      tx_act_q  <= tx_act_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      rx_s1_q   <= RX;
      rx_s2_q   <= rx_s1_q;
      rx_act_q  <= rx_act_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      rx_rdy_q  <= rx_rdy_d;
    end
  end

  assign TX      = tx_q;
  assign rx_rdy  = rx_rdy_q;
  assign rx_data = rx_data_q;

endmodule

// File: rtl/comm_master_n.sv
// UART command master: sends a multi-byte command MSB byte first, then awaits a
// one-byte response with a bounded timeout.
import comm_pkg::*;

module comm_master_n #(
  parameter int unsigned CMD_BYTES   = 2,
  parameter int unsigned BAUD_DIV    = DEFAULT_BAUD_DIV,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   snd_cmd,
  input  logic [8*CMD_BYTES-1:0] cmd,
  input  logic                   RX,
  output logic                   TX,
  output logic                   busy,
  output logic                   cmd_cmplt,
  output logic [7:0]             resp,
  output logic                   resp_cmplt,
  output logic                   resp_timeout
);

  localparam int unsigned BCW = $clog2(CMD_BYTES + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT_CYC - 1);

  cm_state_t              state_q, state_d;
  logic [8*CMD_BYTES-1:0] shadow_q, shadow_d;
  logic [BCW-1:0]         byte_cnt_q, byte_cnt_d;
  logic [TCW-1:0]         tcnt_q, tcnt_d;
  logic                   busy_q, busy_d;
  logic                   cmd_cmplt_q, cmd_cmplt_d;
  logic [7:0]             resp_q, resp_d;
  logic                   resp_cmplt_q, resp_cmplt_d;
  logic                   resp_timeout_q, resp_timeout_d;

  logic       tx_start, tx_done, rx_rdy;
  logic [7:0] tx_byte, rx_data;

  uart_xcvr #(.BAUD_DIV(BAUD_DIV)) u_xcvr (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_start(tx_start),
    .tx_data (tx_byte),
    .tx_done (tx_done),
    .TX      (TX),
    .RX      (RX),
    .rx_rdy  (rx_rdy),
    .rx_data (rx_data)
  );

  // Select the shadow byte indexed by the down-counting byte counter.
  always_comb begin
    tx_byte = '0;
    for (int unsigned i = 0; i < CMD_BYTES; i++) begin
      if (byte_cnt_q == BCW'(i)) tx_byte = shadow_q[8*i +: 8];
    end
  end

  // Next-state and output logic; a response beats a same-cycle timeout.
  always_comb begin
    state_d        = state_q;
    shadow_d       = shadow_q;
    byte_cnt_d     = byte_cnt_q;
    tcnt_d         = tcnt_q;
    busy_d         = busy_q;
    cmd_cmplt_d    = cmd_cmplt_q;
    resp_d         = resp_q;
    resp_cmplt_d   = 1'b0;
    resp_timeout_d = 1'b0;
    tx_start       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (snd_cmd) begin
          shadow_d    = cmd;
          byte_cnt_d  = BCW'(CMD_BYTES - 1);
          cmd_cmplt_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        tx_start = 1'b1;
        state_d  = SEND;
      end
      SEND: begin
        if (tx_done) begin
          if (byte_cnt_q == '0) begin
            cmd_cmplt_d = 1'b1;
            tcnt_d      = '0;
            state_d     = WAIT_RESP;
          end else begin
            byte_cnt_d = byte_cnt_q - 1'b1;
            state_d    = LOAD;
          end
        end
      end
      WAIT_RESP: begin
        tcnt_d = tcnt_q + 1'b1;
        if (rx_rdy) begin
          resp_d       = rx_data;
          resp_cmplt_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else if (tcnt_q == T_LAST) begin
          resp_timeout_d = 1'b1;
          busy_d         = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register state and all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      shadow_q       <= '0;
      byte_cnt_q     <= '0;
      tcnt_q         <= '0;
      busy_q         <= 1'b0;
      cmd_cmplt_q    <= 1'b0;
      resp_q         <= '0;
      resp_cmplt_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      byte_cnt_q     <= byte_cnt_d;
      tcnt_q         <= tcnt_d;
      busy_q         <= busy_d;
      cmd_cmplt_q    <= cmd_cmplt_d;
      resp_q         <= resp_d;
      resp_cmplt_q   <= resp_cmplt_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end

  assign busy         = busy_q;
  assign cmd_cmplt    = cmd_cmplt_q;
  assign resp         = resp_q;
  assign resp_cmplt   = resp_cmplt_q;
  assign resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_comm_master_n.sv
// Self-checking bench for comm_master_n: UART frame decoder on TX, frame driver on RX.
module tb_comm_master_n;

  localparam int NB    = 4;
  localparam int B     = 16;
  localparam int TO    = 500;
  localparam int FRAME = 10 * B + 1;

  logic        clk = 1'b0;
  logic        rst_n, snd_cmd, RX;
  logic [31:0] cmd;
  logic        TX, busy, cmd_cmplt, resp_cmplt, resp_timeout;
  logic [7:0]  resp;

  comm_master_n #(.CMD_BYTES(NB), .BAUD_DIV(B), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .snd_cmd     (snd_cmd),
    .cmd         (cmd),
    .RX          (RX),
    .TX          (TX),
    .busy        (busy),
    .cmd_cmplt   (cmd_cmplt),
    .resp        (resp),
    .resp_cmplt  (resp_cmplt),
    .resp_timeout(resp_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  // Pulse counters with the cycle of the most recent pulse.
  int n_rc = 0, n_to = 0, rc_cyc = -1;
  always @(negedge clk) begin
    if (resp_cmplt === 1'b1) begin
      n_rc   <= n_rc + 1;
      rc_cyc <= cyc;
    end
    if (resp_timeout === 1'b1) n_to <= n_to + 1;
  end

  // TX frame decoder: bytes and the cycle their start bit appeared.
  logic [7:0] mon_q[$];
  int         mon_cyc[$];
  initial begin : txmon
    logic [7:0] b;
    int         s;
    logic       ok;
    forever begin
      @(negedge clk);
      if (TX === 1'b0) begin
        s  = cyc;
        ok = 1'b1;
        repeat (B / 2) @(negedge clk);
        if (TX !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          b[i] = TX;
        end
        repeat (B) @(negedge clk);
        if (TX !== 1'b1) ok = 1'b0;
        if (ok) begin
          mon_q.push_back(b);
          mon_cyc.push_back(s);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [31:0] c, output int c0);
    snd_cmd = 1'b1;
    cmd     = c;
    c0      = cyc;
    tick(1);
    snd_cmd = 1'b0;
    cmd     = $urandom;
  endtask

  task automatic wait_cmplt(input int c0, output int t);
    t = -1;
    for (int k = 0; k < 2000; k++) begin
      if (cmd_cmplt === 1'b1) begin
        t = cyc;
        break;
      end
      tick(1);
    end
    check("cmd_cmplt_latency", t - c0, NB * FRAME + 1);
  endtask

  // Expected wire order is the command split MSB byte first, one frame slot apart.
  task automatic check_bytes(input logic [31:0] c, input int c0);
    logic [7:0] e;
    tick(1);
    check("tx_byte_count", mon_q.size(), NB);
    for (int i = 0; i < NB; i++) begin
      e = c[8*(NB-1-i) +: 8];
      if (i < mon_q.size()) begin
        check("tx_byte_value", {24'h0, mon_q[i]}, {24'h0, e});
        check("tx_byte_start", mon_cyc[i] - c0, 2 + i * FRAME);
      end
    end
    mon_q.delete();
    mon_cyc.delete();
  endtask

  task automatic send_rx(input logic [7:0] v);
    logic [9:0] f;
    f = {1'b1, v, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      tick(B);
    end
  endtask

  initial begin
    int          c0, t, r, lat, rc0, to0, tcyc;
    logic [31:0] c;
    logic [7:0]  v, prev;

    rst_n = 1'b0; snd_cmd = 1'b0; cmd = '0; RX = 1'b1;
    tick(3);
    check("rst_TX", TX, 1);
    check("rst_busy", busy, 0);
    check("rst_cmd_cmplt", cmd_cmplt, 0);
    check("rst_resp", resp, 0);
    check("rst_resp_cmplt", resp_cmplt, 0);
    check("rst_resp_timeout", resp_timeout, 0);
    rst_n = 1'b1;
    tick(2);

    // Directed command with a 3C response; also measures RX-to-resp_cmplt latency.
    send_cmd(32'h0102_0304, c0);
    check("busy_on_accept", busy, 1);
    wait_cmplt(c0, t);
    check_bytes(32'h0102_0304, c0);
    tick(20);
    rc0 = n_rc; to0 = n_to; r = cyc;
    send_rx(8'h3C);
    tick(5);
    lat = rc_cyc - r;
    check("resp_cmplt_once", n_rc - rc0, 1);
    check("resp_value", resp, 8'h3C);
    check("busy_after_resp", busy, 0);
    check("cmd_cmplt_holds", cmd_cmplt, 1);
    check("no_timeout", n_to - to0, 0);
    check("resp_latency_window", (lat >= 9 * B + B / 2 + 2 && lat <= 9 * B + B / 2 + 5), 1);
    prev = 8'h3C;

    // Random commands with a conflicting snd_cmd during SEND and random response delay.
    for (int it = 0; it < 4; it++) begin
      c = $urandom;
      v = 8'($urandom_range(0, 255));
      send_cmd(c, c0);
      check("cmd_cmplt_cleared", cmd_cmplt, 0);
      tick($urandom_range(5, 300));
      snd_cmd = 1'b1; cmd = ~c;
      tick(1);
      snd_cmd = 1'b0;
      wait_cmplt(c0, t);
      check_bytes(c, c0);
      tick($urandom_range(0, 300));
      rc0 = n_rc; to0 = n_to;
      send_rx(v);
      tick(10);
      check("rnd_resp_once", n_rc - rc0, 1);
      check("rnd_resp_value", resp, v);
      check("rnd_no_timeout", n_to - to0, 0);
      check("rnd_busy_low", busy, 0);
      prev = v;
    end

    // No responder: timeout exactly TO cycles after cmd_cmplt.
    c = $urandom;
    send_cmd(c, c0);
    wait_cmplt(c0, t);
    check_bytes(c, c0);
    rc0 = n_rc; to0 = n_to; tcyc = -1;
    for (int k = 0; k < TO + 100; k++) begin
      if (resp_timeout === 1'b1) begin
        tcyc = cyc;
        break;
      end
      tick(1);
    end
    check("timeout_latency", tcyc - t, TO);
    check("timeout_busy_low", busy, 0);
    tick(3);
    check("timeout_once", n_to - to0, 1);
    check("timeout_no_resp", n_rc - rc0, 0);
    check("timeout_resp_kept", resp, prev);

    // Response landing on the final timeout cycle wins.
    c = $urandom; v = 8'($urandom_range(0, 255));
    send_cmd(c, c0);
    wait_cmplt(c0, t);
    check_bytes(c, c0);
    rc0 = n_rc; to0 = n_to;
    wait_until(t + TO - lat);
    send_rx(v);
    tick(10);
    check("edge_resp_once", n_rc - rc0, 1);
    check("edge_resp_cycle", rc_cyc - t, TO);
    check("edge_no_timeout", n_to - to0, 0);
    check("edge_resp_value", resp, v);
    prev = v;

    // One cycle later: timeout fires, late byte is dropped in IDLE.
    c = $urandom; v = ~prev;
    send_cmd(c, c0);
    wait_cmplt(c0, t);
    check_bytes(c, c0);
    rc0 = n_rc; to0 = n_to;
    wait_until(t + TO + 1 - lat);
    send_rx(v);
    tick(10);
    check("late_timeout_once", n_to - to0, 1);
    check("late_no_resp", n_rc - rc0, 0);
    check("late_resp_kept", resp, prev);

    // Reset during the start bit of the second byte.
    c = $urandom;
    send_cmd(c, c0);
    wait_until(c0 + 2 + FRAME + 5);
    check("mid_start_bit_low", TX, 0);
    rst_n = 1'b0;
    #1;
    check("arst_TX", TX, 1);
    check("arst_busy", busy, 0);
    check("arst_cmd_cmplt", cmd_cmplt, 0);
    check("arst_resp", resp, 0);
    check("arst_resp_cmplt", resp_cmplt, 0);
    check("arst_resp_timeout", resp_timeout, 0);
    tick(1);
    rst_n = 1'b1;
    rc0 = n_rc; to0 = n_to;
    tick(12 * B);
    check("post_rst_no_resp", n_rc - rc0, 0);
    check("post_rst_no_timeout", n_to - to0, 0);
    check("post_rst_TX_idle", TX, 1);
    mon_q.delete();
    mon_cyc.delete();

    // Fresh transaction after reset completes normally.
    c = $urandom; v = 8'($urandom_range(0, 255));
    send_cmd(c, c0);
    wait_cmplt(c0, t);
    check_bytes(c, c0);
    rc0 = n_rc;
    send_rx(v);
    tick(10);
    check("fresh_resp_once", n_rc - rc0, 1);
    check("fresh_resp_value", resp, v);
    check("fresh_busy_low", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/comm_master_n.md
# comm_master_n

Parametrised UART command master: serialises a CMD_BYTES-wide command MSB-byte-first onto TX, then waits for a single 8-bit response on RX with a bounded timeout. It is the host-side end of the command link, paired with the remote-side UART wrapper. It adds configurable command width, configurable baud divisor, a response timeout and a busy indication.

## Interface
- CMD_BYTES, 2: command length in bytes, 1..8.
- BAUD_DIV, 2604: clock cycles per UART bit, minimum 8.
- TIMEOUT_CYC, 1_000_000: cycles allowed from end of last command stop bit to response received, minimum 1.
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- snd_cmd  in  1  single-cycle request to send `cmd`.
- cmd  in  8*CMD_BYTES  command word; sampled only on the accepted snd_cmd cycle.
- RX  in  1  UART serial in (asynchronous; double-flopped internally).
- TX  out  1  UART serial out, idle high.
- busy  out  1  high from accepted snd_cmd until response or timeout.
- cmd_cmplt  out  1  level; set when the last command byte's stop bit ends; cleared on next accepted snd_cmd.
- resp  out  8  last received response byte; holds until next response.
- resp_cmplt  out  1  one-cycle pulse, response valid in `resp`.
- resp_timeout  out  1  one-cycle pulse, no response within TIMEOUT_CYC.

## Operation
- States: IDLE, LOAD, SEND, WAIT_RESP.
- IDLE: snd_cmd=1 -> latch cmd into shadow register, byte_cnt=CMD_BYTES-1, clear cmd_cmplt, busy=1, go LOAD. snd_cmd while busy is ignored (no queueing).
- LOAD: present byte `shadow[8*byte_cnt +: 8]` to the transmitter, pulse tx_start, go SEND.
- SEND: on tx_done, byte_cnt==0 -> set cmd_cmplt, clear timeout counter, go WAIT_RESP; else decrement byte_cnt, go LOAD.
- WAIT_RESP: counter increments each cycle. rx_rdy -> resp<=rx_data, pulse resp_cmplt, busy=0, go IDLE. Counter reaching TIMEOUT_CYC-1 without rx_rdy -> pulse resp_timeout, busy=0, go IDLE.
- rx_rdy and timeout in same cycle: response wins; resp_timeout not asserted.
- Bytes received in IDLE/LOAD/SEND are discarded (resp unchanged, no pulse).
- Frame: 1 start (0), 8 data LSB-first, 1 stop (1). Receiver samples at mid-bit (BAUD_DIV/2 after start edge); stop bit = 0 -> byte discarded (framing error, no rx_rdy).
- Timeout counter width $clog2(TIMEOUT_CYC+1); byte_cnt width $clog2(CMD_BYTES+1); no wrap possible by construction.

## Timing
- Reset values: TX=1, busy=0, cmd_cmplt=0, resp=8'h00, resp_cmplt=0, resp_timeout=0, state IDLE.
- Reset mid-frame: TX returns high asynchronously; partial byte lost; no pulses after release.
- Start bit of first byte drives TX 2 cycles after the snd_cmd cycle (IDLE->LOAD->SEND).
- Each byte occupies exactly 10*BAUD_DIV cycles on TX; one idle (high) cycle between consecutive bytes (LOAD).
- cmd_cmplt rises the cycle after last stop bit completes; total ≈ CMD_BYTES*(10*BAUD_DIV+1)+1 cycles.
- resp_cmplt asserts 2-3 cycles after the RX mid-stop-bit sample (sync + register).
- All outputs registered.

## Structure
- Package comm_pkg: state enum cm_state_t, UART_FRAME_BITS=10, DEFAULT_BAUD_DIV.
- Sub-module uart_xcvr #(BAUD_DIV): independent TX and RX halves; ports tx_start, tx_data[7:0], tx_done, TX, RX, rx_rdy, rx_data[7:0]. comm_master_n holds only FSM, shadow register, byte counter, timeout counter.

## Test plan
- CMD_BYTES=2, BAUD_DIV=16: send cmd=16'hA55A, loopback responder returns 8'h3C -> remote sees bytes A5 then 5A, cmd_cmplt at expected cycle, resp_cmplt once, resp=8'h3C, busy low after.
- CMD_BYTES=4: cmd=32'h0102_0304 -> TX bytes 01,02,03,04 in order, 4*161+1 cycles to cmd_cmplt.
- No responder, TIMEOUT_CYC=500 -> resp_timeout pulses exactly 500 cycles after cmd_cmplt, resp unchanged, busy low.
- Response arriving on the final timeout cycle -> resp_cmplt only, no resp_timeout.
- snd_cmd pulsed again mid-SEND with different cmd -> ignored; original bytes transmitted unchanged.
- rst_n low during second byte -> TX high immediately, all outputs at reset values; fresh snd_cmd then completes normally.
